cpu_mc_core: RTL and testbench
==============================

// Module: cpu_mc_core
// PURPOSE
//   Parametrised multi-cycle successor to the single-cycle 8-bit CPU top.
//   Fetches from instruction memory and executes the team ISA with a FSM.
//   Stalls on both memory handshakes and supports configurable data/register widths.
//   Adds BNE and illegal-opcode halt. Sits between instruction memory and data memory/cache.
// PARAMETERS
//   DATA_W      8   register/ALU/data-bus width (>=8)
//   REG_ADDR_W  3   register index width; 2**REG_ADDR_W registers
//   PC_W       32   program counter width
//   ADDR_W      8   data-memory address width
// PORTS
//   CLK          in   1        single clock, rising edge
//   RESET_N      in   1        asynchronous, active-low reset
//   PC           out  PC_W     instruction address (byte address, word aligned)
//   INSTRUCTION  in   32       instruction word for PC
//   IBUSYWAIT    in   1        1 = INSTRUCTION not yet valid
//   READ         out  1        data-memory read strobe
//   WRITE        out  1        data-memory write strobe
//   ADDRESS      out  ADDR_W   data-memory address
//   WRITEDATA    out  DATA_W   store data
//   READDATA     in   DATA_W   load data
//   BUSYWAIT     in   1        1 = data access in progress
//   HALTED       out  1        1 = core stopped on illegal opcode
// BEHAVIOUR
//   Encoding:
//   - [31:24] opcode; [23:16] rd (low REG_ADDR_W bits) or branch offset.
//   - [15:8] rs1; [7:0] rs2 (low bits) or imm.
//   - imm and offset are sign-extended.
//   Opcodes:
//   - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 MOV, 5 LOADI, 6 J, 7 BEQ, 8 BNE.
//   - 9 LWD (rd<-M[rs2]), 10 LWI (rd<-M[imm]).
//   - 11 SWD (M[rs2]<-rs1), 12 SWI (M[imm]<-rs1).
//   - Others are illegal.
//   Reset (async, RESET_N=0):
//   - PC=0, state=FETCH, all registers=0.
//   - READ=WRITE=0, ADDRESS=0, WRITEDATA=0, HALTED=0.
//   - Reset mid-access drops strobes immediately.
//   States:
//   - FETCH: edge with IBUSYWAIT=0 latches INSTRUCTION into IR and goes to EXEC.
//     Otherwise stays, with PC stable.
//   - EXEC: reads rs1/rs2 and computes the ALU result (SUB = rs1 + ~rs2 + 1, wrap mod 2**DATA_W).
//     - ALU/LOADI/MOV ops write rd at the EXEC edge and set PC += 4, then go to FETCH.
//     - J: PC = PC + 4 + (sext(off) << 2).
//     - BEQ/BNE: take that target iff (rs1 - rs2 == 0) / (!= 0); else PC += 4.
//     - Loads/stores: register ADDRESS = low ADDR_W bits of the address operand (zero-extended if DATA_W < ADDR_W).
//       Register WRITEDATA = rs1, then go to MEM.
//     - Illegal opcode: go to HALT.
//   - MEM: READ (loads) or WRITE (stores) high for the whole state.
//     - ADDRESS and WRITEDATA are held constant.
//     - Completion is the first edge in MEM with BUSYWAIT=0.
//     - On completion a load writes READDATA to rd, strobes drop, PC += 4, then go to FETCH.
//     - The memory may drive BUSYWAIT combinationally in the strobe cycle.
//     - Zero-wait memory completes MEM in 1 cycle.
//   - HALT: HALTED=1, no strobes, no writes, PC frozen, left only by reset.
//   Latency (no waits): ALU/branch = 2 cycles, load/store = 3 cycles.
//   Register writes are synchronous, and a write to rd is visible to the next instruction's EXEC.
//   PC wraps modulo 2**PC_W.
//   READ and WRITE are never both high.
// STRUCTURE
//   Shared package cpu_pkg:
//   - opcode localparams.
//   - state encoding FETCH/EXEC/MEM/HALT.
//   - field-slice constants.
//   Sub-module cpu_alu_p #(DATA_W): combinational ADD/SUB/AND/OR/FWD and zero flag.
//   Register file, IR, PC and FSM are in this module.
// TESTING
//   1. LOADI r1,5; LOADI r2,3; SUB r3,r1,r2; zero-wait -> r3=2, PC=12 after 6 cycles.
//   2. LOADI r1,7; LOADI r2,7; BEQ off=2 -> PC jumps 8->20; the same test with BNE -> PC=12.
//   3. SWI r1(=0x2A),imm=0x10 then LWI r4,0x10 with BUSYWAIT high 5 cycles each.
//      -> WRITE high 6 cycles with ADDRESS=0x10, WRITEDATA=0x2A; r4=0x2A; PC stable while stalled.
//   4. IBUSYWAIT high 4 cycles on the first fetch -> PC stays 0, no register write, then normal execution.
//   5. Opcode 0xFF -> HALTED=1 on the next cycle; PC and registers frozen for 20 cycles; RESET_N pulse clears it.
//   6. RESET_N low during MEM wait -> READ/WRITE drop asynchronously; PC=0 and state FETCH on release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle core: opcodes, FSM states,
// ALU operations and instruction field positions.
package cpu_pkg;

    localparam logic [7:0] OP_ADD   = 8'd0;
    localparam logic [7:0] OP_SUB   = 8'd1;
    localparam logic [7:0] OP_AND   = 8'd2;
    localparam logic [7:0] OP_OR    = 8'd3;
    localparam logic [7:0] OP_MOV   = 8'd4;
    localparam logic [7:0] OP_LOADI = 8'd5;
    localparam logic [7:0] OP_J     = 8'd6;
    localparam logic [7:0] OP_BEQ   = 8'd7;
    localparam logic [7:0] OP_BNE   = 8'd8;
    localparam logic [7:0] OP_LWD   = 8'd9;
    localparam logic [7:0] OP_LWI   = 8'd10;
    localparam logic [7:0] OP_SWD   = 8'd11;
    localparam logic [7:0] OP_SWI   = 8'd12;

    localparam int FIELD_W = 8;
    localparam int OPC_LSB = 24;
    localparam int RD_LSB  = 16;
    localparam int RS1_LSB = 8;
    localparam int RS2_LSB = 0;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MEM   = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_FWD = 3'd4
    } alu_op_e;

endpackage

// File: rtl/cpu_alu_p.sv
// Combinational ALU for the multi-cycle core; the zero flag drives BEQ/BNE.
module cpu_alu_p
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  alu_op_e           alu_op,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    // Operation select; SUB is two's-complement add so it wraps naturally
    always_comb begin
        result = op_b;
        case (alu_op)
            ALU_ADD: result = op_a + op_b;
            ALU_SUB: result = op_a + ~op_b + {{(DATA_W-1){1'b0}}, 1'b1};
            ALU_AND: result = op_a & op_b;
            ALU_OR:  result = op_a | op_b;
            ALU_FWD: result = op_b;
            default: result = op_b;
        endcase
    end

    assign zero = (result == {DATA_W{1'b0}});

endmodule

// File: rtl/cpu_mc_core.sv
// Multi-cycle core: FETCH/EXEC/MEM/HALT FSM with register file, IR and PC,
// stalling on both the instruction and data memory handshakes.
module cpu_mc_core
    import cpu_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int REG_ADDR_W = 3,
    parameter int PC_W       = 32,
    parameter int ADDR_W     = 8
) (
    input  logic              CLK,
    input  logic              RESET_N,
    output logic [PC_W-1:0]   PC,
    input  logic [31:0]       INSTRUCTION,
    input  logic              IBUSYWAIT,
    output logic              READ,
    output logic              WRITE,
    output logic [ADDR_W-1:0] ADDRESS,
    output logic [DATA_W-1:0] WRITEDATA,
    input  logic [DATA_W-1:0] READDATA,
    input  logic              BUSYWAIT,
    output logic              HALTED
);

    localparam int NREG  = 2 ** REG_ADDR_W;
    localparam int EXT_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [31:0]         ir_q, ir_d;
    logic                read_q, read_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                halted_q, halted_d;
    logic [DATA_W-1:0]   regs_q [NREG];

    logic [7:0]            opc_s, rd_f_s, rs1_f_s, rs2_f_s;
    logic [REG_ADDR_W-1:0] rd_idx_s;
    logic [DATA_W-1:0]     rs1_val_s, rs2_val_s, imm_sext_s, op_b_s, alu_res_s;
    logic [DATA_W-1:0]     mem_opnd_s;
    logic [EXT_W-1:0]      mem_opnd_ext_s;
    logic [ADDR_W-1:0]     mem_addr_s;
    logic [PC_W-1:0]       pc_plus4_s, off_sext_s, br_tgt_s;
    logic                  alu_zero_s;
    alu_op_e               alu_op_s;
    logic                  rf_we_s;
    logic [DATA_W-1:0]     rf_wdata_s;
    logic                  unused_fields_s;

    assign opc_s   = ir_q[OPC_LSB +: FIELD_W];
    assign rd_f_s  = ir_q[RD_LSB  +: FIELD_W];
    assign rs1_f_s = ir_q[RS1_LSB +: FIELD_W];
    assign rs2_f_s = ir_q[RS2_LSB +: FIELD_W];
    assign unused_fields_s = ^rs1_f_s;

    assign rd_idx_s   = rd_f_s[REG_ADDR_W-1:0];
    assign rs1_val_s  = regs_q[rs1_f_s[REG_ADDR_W-1:0]];
    assign rs2_val_s  = regs_q[rs2_f_s[REG_ADDR_W-1:0]];
    assign imm_sext_s = DATA_W'($signed(rs2_f_s));

    // Branch offsets count words, so the sign-extended offset is scaled by 4
    assign pc_plus4_s = pc_q + PC_W'(32'd4);
    assign off_sext_s = PC_W'($signed(rd_f_s));
    assign br_tgt_s   = pc_plus4_s + (off_sext_s << 2);

    // Register-direct forms address through rs2, immediate forms through imm
    assign mem_opnd_s     = ((opc_s == OP_LWD) || (opc_s == OP_SWD)) ? rs2_val_s : imm_sext_s;
    assign mem_opnd_ext_s = EXT_W'(mem_opnd_s);
    assign mem_addr_s     = mem_opnd_ext_s[ADDR_W-1:0];

    // ALU operation and second-operand selection from the opcode
    always_comb begin
        alu_op_s = ALU_FWD;
        op_b_s   = rs2_val_s;
        case (opc_s)
            OP_ADD:                  alu_op_s = ALU_ADD;
            OP_SUB, OP_BEQ, OP_BNE:  alu_op_s = ALU_SUB;
            OP_AND:                  alu_op_s = ALU_AND;
            OP_OR:                   alu_op_s = ALU_OR;
            OP_MOV:                  alu_op_s = ALU_FWD;
            OP_LOADI: begin
                alu_op_s = ALU_FWD;
                op_b_s   = imm_sext_s;
            end
            default:                 alu_op_s = ALU_FWD;
        endcase
    end

    cpu_alu_p #(.DATA_W(DATA_W)) u_alu (
        .alu_op (alu_op_s),
        .op_a   (rs1_val_s),
        .op_b   (op_b_s),
        .result (alu_res_s),
        .zero   (alu_zero_s)
    );

    // FSM next-state, PC, memory-interface and register-write decisions
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        read_d     = read_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        halted_d   = halted_q;
        rf_we_s    = 1'b0;
        rf_wdata_s = alu_res_s;
        case (state_q)
            ST_FETCH: begin
                if (!IBUSYWAIT) begin
                    ir_d    = INSTRUCTION;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                case (opc_s)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MOV, OP_LOADI: begin
                        rf_we_s = 1'b1;
                        pc_d    = pc_plus4_s;
                    end
                    OP_J:   pc_d = br_tgt_s;
                    OP_BEQ: pc_d = alu_zero_s ? br_tgt_s : pc_plus4_s;
                    OP_BNE: pc_d = alu_zero_s ? pc_plus4_s : br_tgt_s;
                    OP_LWD, OP_LWI: begin
                        read_d  = 1'b1;
                        addr_d  = mem_addr_s;
                        wdata_d = rs1_val_s;
                        state_d = ST_MEM;
                    end
                    OP_SWD, OP_SWI: begin
                        write_d = 1'b1;
                        addr_d  = mem_addr_s;
                        wdata_d = rs1_val_s;
                        state_d = ST_MEM;
                    end
                    default: begin
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end
                endcase
            end
            ST_MEM: begin
                if (!BUSYWAIT) begin
                    rf_we_s    = read_q;
                    rf_wdata_s = READDATA;
                    read_d     = 1'b0;
                    write_d    = 1'b0;
                    pc_d       = pc_plus4_s;
                    state_d    = ST_FETCH;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_HALT: begin
                read_d   = 1'b0;
                write_d  = 1'b0;
                halted_d = 1'b1;
                state_d  = ST_HALT;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // Control, PC and memory-interface state registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= ST_FETCH;
            pc_q     <= {PC_W{1'b0}};
            ir_q     <= 32'd0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= {ADDR_W{1'b0}};
            wdata_q  <= {DATA_W{1'b0}};
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            read_q   <= read_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            halted_q <= halted_d;
        end
    end

    // Register file with synchronous write port
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
        end else if (rf_we_s) begin
            regs_q[rd_idx_s] <= rf_wdata_s;
        end
    end

    assign PC        = pc_q;
    assign READ      = read_q;
    assign WRITE     = write_q;
    assign ADDRESS   = addr_q;
    assign WRITEDATA = wdata_q;
    assign HALTED    = halted_q;

endmodule

// File: tb/tb_cpu_mc_core.sv
// Directed bench for cpu_mc_core with behavioural instruction and data memories;
// register contents are observed by storing them to data memory.
module tb_cpu_mc_core;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [31:0] PC;
    logic [31:0] INSTRUCTION;
    logic        IBUSYWAIT = 1'b0;
    logic        READ, WRITE;
    logic [7:0]  ADDRESS, WRITEDATA, READDATA;
    logic        BUSYWAIT;
    logic        HALTED;

    logic [31:0] imem [0:63];
    logic [7:0]  dmem [0:255];
    int          dwait = 0;
    int          bcnt = 0;
    int          wr_cycles = 0;
    int          rd_cycles = 0;
    logic [7:0]  last_wa = 8'd0;
    logic [7:0]  last_wd = 8'd0;
    int          n_vec = 0;
    int          n_miss = 0;
    int          wr0, rd0;

    cpu_mc_core #(.DATA_W(8), .REG_ADDR_W(3), .PC_W(32), .ADDR_W(8)) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .PC          (PC),
        .INSTRUCTION (INSTRUCTION),
        .IBUSYWAIT   (IBUSYWAIT),
        .READ        (READ),
        .WRITE       (WRITE),
        .ADDRESS     (ADDRESS),
        .WRITEDATA   (WRITEDATA),
        .READDATA    (READDATA),
        .BUSYWAIT    (BUSYWAIT),
        .HALTED      (HALTED)
    );

    always #5 CLK = ~CLK;

    assign INSTRUCTION = imem[PC[7:2]];
    assign READDATA    = dmem[ADDRESS];
    assign BUSYWAIT    = (READ || WRITE) && (bcnt < dwait);

    // Data memory: busy for dwait cycles of each access, then completes
    always @(posedge CLK) begin
        bcnt <= (READ || WRITE) ? bcnt + 1 : 0;
        if (WRITE) wr_cycles <= wr_cycles + 1;
        if (READ)  rd_cycles <= rd_cycles + 1;
        if (WRITE && !BUSYWAIT) begin
            dmem[ADDRESS] <= WRITEDATA;
            last_wa       <= ADDRESS;
            last_wd       <= WRITEDATA;
        end
    end

    function automatic logic [31:0] enc(input logic [7:0] op, input logic [7:0] rd,
                                        input logic [7:0] rs1, input logic [7:0] rs2);
        return {op, rd, rs1, rs2};
    endfunction

    task automatic chk_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) imem[i] = 32'hFF00_0000;
    endtask

    task automatic apply_reset();
        RESET_N   = 1'b0;
        IBUSYWAIT = 1'b0;
        tick(2);
        RESET_N = 1'b1;
    endtask

    initial begin
        // Reset values
        clear_prog();
        RESET_N = 1'b0;
        tick(2);
        chk_vec("rst_pc", PC, 32'd0);
        chk_vec("rst_read", {31'd0, READ}, 32'd0);
        chk_vec("rst_write", {31'd0, WRITE}, 32'd0);
        chk_vec("rst_addr", {24'd0, ADDRESS}, 32'd0);
        chk_vec("rst_wdata", {24'd0, WRITEDATA}, 32'd0);
        chk_vec("rst_halted", {31'd0, HALTED}, 32'd0);

        // 1: LOADI/LOADI/SUB then store r3
        clear_prog();
        imem[0] = enc(8'd5, 8'd1, 8'd0, 8'd5);
        imem[1] = enc(8'd5, 8'd2, 8'd0, 8'd3);
        imem[2] = enc(8'd1, 8'd3, 8'd1, 8'd2);
        imem[3] = enc(8'd12, 8'd0, 8'd3, 8'h20);
        dwait = 0;
        apply_reset();
        tick(2);
        chk_vec("t1_pc2", PC, 32'd4);
        tick(4);
        chk_vec("t1_pc6", PC, 32'd12);
        tick(3);
        chk_vec("t1_pc9", PC, 32'd16);
        chk_vec("t1_r3", {24'd0, last_wd}, 32'd2);
        chk_vec("t1_addr", {24'd0, last_wa}, 32'h20);

        // 2a: BEQ taken
        clear_prog();
        imem[0] = enc(8'd5, 8'd1, 8'd0, 8'd7);
        imem[1] = enc(8'd5, 8'd2, 8'd0, 8'd7);
        imem[2] = enc(8'd7, 8'd2, 8'd1, 8'd2);
        apply_reset();
        tick(6);
        chk_vec("t2_beq", PC, 32'd20);
        // 2b: BNE not taken
        imem[2] = enc(8'd8, 8'd2, 8'd1, 8'd2);
        apply_reset();
        tick(6);
        chk_vec("t2_bne_nt", PC, 32'd12);
        // 2c: BNE taken
        imem[1] = enc(8'd5, 8'd2, 8'd0, 8'd3);
        imem[2] = enc(8'd8, 8'd1, 8'd1, 8'd2);
        apply_reset();
        tick(6);
        chk_vec("t2_bne_tk", PC, 32'd16);
        // 2d: J with negative offset
        clear_prog();
        imem[0] = enc(8'd5, 8'd1, 8'd0, 8'd1);
        imem[1] = enc(8'd6, 8'hFE, 8'd0, 8'd0);
        apply_reset();
        tick(4);
        chk_vec("t2_jneg", PC, 32'd0);

        // 3: stalled store and load
        clear_prog();
        imem[0] = enc(8'd5, 8'd1, 8'd0, 8'h2A);
        imem[1] = enc(8'd12, 8'd0, 8'd1, 8'h10);
        imem[2] = enc(8'd10, 8'd4, 8'd0, 8'h10);
        imem[3] = enc(8'd12, 8'd0, 8'd4, 8'h30);
        dwait = 5;
        apply_reset();
        wr0 = wr_cycles;
        rd0 = rd_cycles;
        tick(7);
        chk_vec("t3_sw_pc", PC, 32'd4);
        chk_vec("t3_sw_write", {31'd0, WRITE}, 32'd1);
        chk_vec("t3_sw_read", {31'd0, READ}, 32'd0);
        chk_vec("t3_sw_addr", {24'd0, ADDRESS}, 32'h10);
        chk_vec("t3_sw_wdata", {24'd0, WRITEDATA}, 32'h2A);
        tick(3);
        chk_vec("t3_sw_done_pc", PC, 32'd8);
        chk_vec("t3_sw_done_wr", {31'd0, WRITE}, 32'd0);
        chk_vec("t3_mem10", {24'd0, dmem[8'h10]}, 32'h2A);
        tick(4);
        chk_vec("t3_lw_read", {31'd0, READ}, 32'd1);
        chk_vec("t3_lw_addr", {24'd0, ADDRESS}, 32'h10);
        chk_vec("t3_lw_pc", PC, 32'd8);
        tick(4);
        chk_vec("t3_lw_done_pc", PC, 32'd12);
        tick(8);
        chk_vec("t3_end_pc", PC, 32'd16);
        chk_vec("t3_r4", {24'd0, last_wd}, 32'h2A);
        chk_vec("t3_r4_addr", {24'd0, last_wa}, 32'h30);
        chk_vec("t3_wr_cycles", wr_cycles - wr0, 32'd12);
        chk_vec("t3_rd_cycles", rd_cycles - rd0, 32'd6);

        // 4: instruction-fetch stall
        clear_prog();
        imem[0] = enc(8'd5, 8'd5, 8'd0, 8'd9);
        imem[1] = enc(8'd12, 8'd0, 8'd5, 8'h40);
        dwait = 0;
        RESET_N = 1'b0;
        tick(2);
        IBUSYWAIT = 1'b1;
        RESET_N = 1'b1;
        wr0 = wr_cycles;
        tick(4);
        chk_vec("t4_stall_pc", PC, 32'd0);
        chk_vec("t4_stall_wr", wr_cycles - wr0, 32'd0);
        IBUSYWAIT = 1'b0;
        tick(2);
        chk_vec("t4_pc", PC, 32'd4);
        tick(3);
        chk_vec("t4_pc2", PC, 32'd8);
        chk_vec("t4_r5", {24'd0, last_wd}, 32'd9);
        chk_vec("t4_addr", {24'd0, last_wa}, 32'h40);

        // 5: illegal opcode halts until reset
        clear_prog();
        imem[0] = enc(8'd5, 8'd1, 8'd0, 8'h11);
        apply_reset();
        tick(3);
        chk_vec("t5_pre_halt", {31'd0, HALTED}, 32'd0);
        tick(1);
        chk_vec("t5_halted", {31'd0, HALTED}, 32'd1);
        chk_vec("t5_pc", PC, 32'd4);
        wr0 = wr_cycles;
        rd0 = rd_cycles;
        tick(20);
        chk_vec("t5_hold_halt", {31'd0, HALTED}, 32'd1);
        chk_vec("t5_hold_pc", PC, 32'd4);
        chk_vec("t5_no_strobe", (wr_cycles - wr0) + (rd_cycles - rd0), 32'd0);
        RESET_N = 1'b0;
        #1;
        chk_vec("t5_rst_halt", {31'd0, HALTED}, 32'd0);
        chk_vec("t5_rst_pc", PC, 32'd0);

        // 6: reset during a stalled load
        clear_prog();
        imem[0] = enc(8'd10, 8'd2, 8'd0, 8'h50);
        dwait = 50;
        apply_reset();
        tick(4);
        chk_vec("t6_read", {31'd0, READ}, 32'd1);
        chk_vec("t6_addr", {24'd0, ADDRESS}, 32'h50);
        RESET_N = 1'b0;
        #1;
        chk_vec("t6_rst_read", {31'd0, READ}, 32'd0);
        chk_vec("t6_rst_write", {31'd0, WRITE}, 32'd0);
        chk_vec("t6_rst_addr", {24'd0, ADDRESS}, 32'd0);
        dwait = 0;
        tick(2);
        RESET_N = 1'b1;
        #1;
        chk_vec("t6_rel_pc", PC, 32'd0);
        tick(2);
        chk_vec("t6_refetch_read", {31'd0, READ}, 32'd1);
        chk_vec("t6_refetch_addr", {24'd0, ADDRESS}, 32'h50);
        tick(1);
        chk_vec("t6_done_pc", PC, 32'd4);
        chk_vec("t6_done_read", {31'd0, READ}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
